// File: rtl/gridworld_pkg.sv
// Shared gridworld types and constants used by the episode scheduler and the reward datapath.
package gridworld_pkg;

  typedef logic [5:0]  cell_t;
  typedef logic [15:0] eps_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_STEP,
    S_EVAL,
    S_ENDEP,
    S_DONE,
    S_FAIL
  } state_t;

  localparam cell_t       START_STATE  = 6'd1;
  localparam cell_t       GOAL_STATE   = 6'd25;
  localparam logic [25:0] HOLE_MASK    = 26'h05A_41A0;
  localparam logic [4:0]  MAX_STEPS    = 5'd15;
  localparam logic [9:0]  MAX_EPISODES = 10'd256;
  localparam logic [3:0]  CONV_GOALS   = 4'd8;
  localparam eps_t        EPS_INIT     = 16'hF000;
  localparam eps_t        EPS_MIN      = 16'h0100;
  localparam int unsigned EPS_SHIFT    = 4;

  // Cells beyond the grid are off the map and count as holes.
  function automatic logic is_hole(input cell_t c);
    logic h;
    h = 1'b1;
    if (c <= GOAL_STATE) h = HOLE_MASK[c[4:0]];
    return h;
  endfunction

endpackage

// File: rtl/episode_scheduler_if.sv
// Run-control and agent handshake bundle between the scheduler and its environment.
interface episode_scheduler_if;
  import gridworld_pkg::*;

  logic       run;
  logic       step_done;
  cell_t      next_state;
  logic       agent_start;
  logic       agent_en;
  cell_t      current_st;
  eps_t       epsilon;
  logic [9:0] episode;
  logic [4:0] step_cnt;
  logic [9:0] goal_cnt;
  logic       print;
  logic       busy;
  logic       finish;
  logic       fail;

  modport master (
    output run, step_done, next_state,
    input  agent_start, agent_en, current_st, epsilon, episode,
           step_cnt, goal_cnt, print, busy, finish, fail
  );

  modport slave (
    input  run, step_done, next_state,
    output agent_start, agent_en, current_st, epsilon, episode,
           step_cnt, goal_cnt, print, busy, finish, fail
  );

endinterface

// File: rtl/episode_scheduler_eps_decay.sv
// Epsilon decay: subtract eps>>EPS_SHIFT and clamp at the floor.
module eps_decay
  import gridworld_pkg::*;
(
  input  eps_t eps_in,
  input  eps_t min,
  output eps_t eps_out
);

  eps_t diff;

  always_comb begin
    diff    = eps_in - (eps_in >> EPS_SHIFT);
    eps_out = (diff < min) ? min : diff;
  end

endmodule

// File: rtl/episode_scheduler.sv
// Episode sequencer: launches episodes, steps the agent, detects goal/hole/timeout,
// decays epsilon per episode and stops on convergence or budget exhaustion.
module episode_scheduler
  import gridworld_pkg::*;
(
  input  logic               clk,
  input  logic               enb,
  episode_scheduler_if.slave bus
);

  state_t     state_q, state_d;
  cell_t      cur_q, cur_d;
  logic [4:0] step_q, step_d;
  logic [9:0] episode_q, episode_d;
  logic [9:0] goal_q, goal_d;
  logic [3:0] consec_q, consec_d;
  eps_t       eps_q, eps_d, eps_dec;
  logic       finish_q, finish_d;
  logic       fail_q, fail_d;

  eps_decay u_eps_decay (
    .eps_in  (eps_q),
    .min     (EPS_MIN),
    .eps_out (eps_dec)
  );

  always_ff @(posedge clk) begin
    if (enb) begin
      state_q   <= S_IDLE;
      cur_q     <= START_STATE;
      step_q    <= '0;
      episode_q <= '0;
      goal_q    <= '0;
      consec_q  <= '0;
      eps_q     <= EPS_INIT;
      finish_q  <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      step_q    <= step_d;
      episode_q <= episode_d;
      goal_q    <= goal_d;
      consec_q  <= consec_d;
      eps_q     <= eps_d;
      finish_q  <= finish_d;
      fail_q    <= fail_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    step_d    = step_q;
    episode_d = episode_q;
    goal_d    = goal_q;
    consec_d  = consec_q;
    eps_d     = eps_q;
    finish_d  = finish_q;
    fail_d    = fail_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d   = S_INIT;
          episode_d = '0;
          goal_d    = '0;
          consec_d  = '0;
          eps_d     = EPS_INIT;
          finish_d  = 1'b0;
          fail_d    = 1'b0;
        end
      end
      S_INIT: begin
        cur_d     = START_STATE;
        step_d    = '0;
        episode_d = episode_q + 10'd1;
        state_d   = S_STEP;
      end
      S_STEP: begin
        if (bus.step_done) begin
          cur_d   = bus.next_state;
          step_d  = step_q + 5'd1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        // Goal beats hole beats timeout; cur_q/step_q already hold this step's result.
        if (cur_q == GOAL_STATE) begin
          goal_d   = (goal_q == 10'h3FF) ? goal_q : goal_q + 10'd1;
          consec_d = consec_q + 4'd1;
          state_d  = S_ENDEP;
        end else if (is_hole(cur_q) || step_q == MAX_STEPS) begin
          consec_d = '0;
          state_d  = S_ENDEP;
        end else begin
          state_d  = S_STEP;
        end
      end
      S_ENDEP: begin
        eps_d = eps_dec;
        if (consec_q == CONV_GOALS) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end else if (episode_q == MAX_EPISODES) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end else begin
          state_d = S_INIT;
        end
      end
      S_DONE, S_FAIL: begin
        // Wait for run to drop so a held run cannot relaunch immediately.
        if (!bus.run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.agent_start = (state_q == S_INIT);
  assign bus.agent_en    = (state_q == S_STEP);
  assign bus.print       = (state_q == S_STEP) || (state_q == S_EVAL);
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign bus.current_st  = cur_q;
  assign bus.epsilon     = eps_q;
  assign bus.episode     = episode_q;
  assign bus.step_cnt    = step_q;
  assign bus.goal_cnt    = goal_q;
  assign bus.finish      = finish_q;
  assign bus.fail        = fail_q;

endmodule

// File: tb/tb_episode_scheduler.sv
// Self-checking bench for episode_scheduler: randomized agent responses against a trajectory-level model.
module tb_episode_scheduler;
  import gridworld_pkg::*;

  logic clk = 1'b0;
  logic enb;
  episode_scheduler_if bus();

  episode_scheduler dut (
    .clk (clk),
    .enb (enb),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_eps, m_goals, m_consec;

  int safe_cells[$] = {1, 2, 3, 4, 6, 9, 10, 11, 12, 13, 15, 16, 18, 21, 23, 24};
  int hole_cells[$] = {5, 7, 8, 14, 17, 19, 20, 22};

  // Outcome of one episode from the cell sequence the agent reports: 0 goal, 1 hole, 2 timeout.
  function automatic void ref_episode(input logic [5:0] traj[$], output int steps, output int kind);
    int c;
    steps = 0;
    kind  = 2;
    for (int i = 0; i < 15; i++) begin
      c = int'(traj[(i < traj.size()) ? i : traj.size() - 1]);
      steps = i + 1;
      if (c == 25) begin kind = 0; return; end
      if (c > 25 || c inside {5, 7, 8, 14, 17, 19, 20, 22}) begin kind = 1; return; end
    end
  endfunction

  function automatic int ref_decay(input int e);
    int d;
    d = e - e / 16;
    return (d < 256) ? 256 : d;
  endfunction

  function automatic void ref_account(input int kind);
    if (kind == 0) begin
      m_goals++;
      m_consec++;
    end else begin
      m_consec = 0;
    end
    m_eps = ref_decay(m_eps);
  endfunction

  task automatic do_reset();
    bus.run = 1'b0;
    bus.step_done = 1'b0;
    bus.next_state = '0;
    enb = 1'b1;
    repeat (3) @(negedge clk);
    enb = 1'b0;
    m_eps = 16'hF000;
    m_goals = 0;
    m_consec = 0;
  endtask

  // Plays the agent for one episode; returns at the negedge where ENDEP is visible.
  task automatic play_episode(input logic [5:0] traj[$], output int steps, output bit timed_out);
    int guard;
    int idx;
    steps = 0;
    timed_out = 1'b0;
    guard = 0;
    while (bus.agent_start !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 20) begin timed_out = 1'b1; return; end
    end
    guard = 0;
    forever begin
      @(negedge clk);
      bus.step_done = 1'b0;
      guard++;
      if (guard > 200) begin timed_out = 1'b1; return; end
      if (bus.agent_en === 1'b1) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        idx = (steps < traj.size()) ? steps : traj.size() - 1;
        bus.step_done = 1'b1;
        bus.next_state = traj[idx];
        @(negedge clk);
        // Stray handshake while in EVAL must be ignored.
        bus.step_done = 1'($urandom_range(0, 1));
        bus.next_state = 6'($urandom_range(0, 63));
        steps++;
      end else if (bus.print !== 1'b1) begin
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [52:0] obs;
    enb = 1'b1;
    bus.run = 1'b1;
    bus.step_done = 1'b1;
    bus.next_state = 6'd25;
    repeat (3) @(negedge clk);
    obs = {bus.agent_start, bus.agent_en, bus.print, bus.busy, bus.finish, bus.fail,
           bus.current_st, bus.epsilon, bus.episode, bus.step_cnt, bus.goal_cnt};
    total++;
    if (obs !== {6'b0, 6'd1, 16'hF000, 10'd0, 5'd0, 10'd0}) begin
      bad++;
      $display("FAIL reset_state: got %h required %h", obs, {6'b0, 6'd1, 16'hF000, 10'd0, 5'd0, 10'd0});
    end
    $display("reset: outputs %h", obs);
    bus.run = 1'b0;
    bus.step_done = 1'b0;
    enb = 1'b0;
  endtask

  task automatic test_hole();
    logic [5:0] traj[$];
    int steps;
    bit to;
    do_reset();
    bus.run = 1'b1;
    traj = {6'd2, 6'd3, 6'd4, 6'd9, 6'd10, 6'd15, 6'd20};
    play_episode(traj, steps, to);
    total++;
    if (to) begin bad++; $display("FAIL hole_timeout: got stalled required ENDEP"); end
    total++;
    if (steps != 7 || bus.step_cnt !== 5'd7) begin
      bad++; $display("FAIL hole_steps: got %0d/%0d required 7", steps, bus.step_cnt);
    end
    total++;
    if ({bus.current_st, bus.goal_cnt, bus.episode} !== {6'd20, 10'd0, 10'd1}) begin
      bad++; $display("FAIL hole_counts: got st=%0d goals=%0d ep=%0d required 20/0/1",
                      bus.current_st, bus.goal_cnt, bus.episode);
    end
    @(negedge clk);
    total++;
    if ({bus.epsilon, bus.agent_start} !== {16'hE100, 1'b1}) begin
      bad++; $display("FAIL hole_eps: got eps=%h start=%b required E100/1", bus.epsilon, bus.agent_start);
    end
    $display("hole episode: steps=%0d st=%0d eps=%h", steps, bus.current_st, bus.epsilon);
  endtask

  task automatic test_goal();
    logic [5:0] traj[$];
    int steps;
    bit to;
    traj = {6'd2, 6'd3, 6'd4, 6'd9, 6'd10, 6'd15, 6'd16, 6'd11, 6'd12, 6'd13, 6'd18, 6'd23, 6'd24, 6'd25};
    play_episode(traj, steps, to);
    total++;
    if (to) begin bad++; $display("FAIL goal_timeout: got stalled required ENDEP"); end
    total++;
    if ({bus.step_cnt, bus.current_st, bus.goal_cnt, bus.episode} !== {5'd14, 6'd25, 10'd1, 10'd2}) begin
      bad++; $display("FAIL goal_counts: got steps=%0d st=%0d goals=%0d ep=%0d required 14/25/1/2",
                      bus.step_cnt, bus.current_st, bus.goal_cnt, bus.episode);
    end
    @(negedge clk);
    total++;
    if ({bus.epsilon, bus.agent_start} !== {16'hD2F0, 1'b1}) begin
      bad++; $display("FAIL goal_restart: got eps=%h start=%b required D2F0/1", bus.epsilon, bus.agent_start);
    end
    $display("goal episode: steps=%0d goals=%0d eps=%h", steps, bus.goal_cnt, bus.epsilon);
  endtask

  task automatic test_timeout();
    logic [5:0] traj[$];
    int steps;
    bit to;
    traj = {6'd1};
    play_episode(traj, steps, to);
    total++;
    if (to) begin bad++; $display("FAIL timeout_stall: got stalled required ENDEP"); end
    total++;
    if ({bus.step_cnt, bus.current_st, bus.goal_cnt, bus.episode} !== {5'd15, 6'd1, 10'd1, 10'd3}) begin
      bad++; $display("FAIL timeout_counts: got steps=%0d st=%0d goals=%0d ep=%0d required 15/1/1/3",
                      bus.step_cnt, bus.current_st, bus.goal_cnt, bus.episode);
    end
    @(negedge clk);
    total++;
    if ({bus.epsilon, bus.agent_start} !== {16'hC5C1, 1'b1}) begin
      bad++; $display("FAIL timeout_restart: got eps=%h start=%b required C5C1/1", bus.epsilon, bus.agent_start);
    end
    @(negedge clk);
    total++;
    if ({bus.episode, bus.step_cnt, bus.agent_en} !== {10'd4, 5'd0, 1'b1}) begin
      bad++; $display("FAIL timeout_next: got ep=%0d steps=%0d en=%b required 4/0/1",
                      bus.episode, bus.step_cnt, bus.agent_en);
    end
    $display("timeout episode: steps=%0d eps=%h", steps, bus.epsilon);
  endtask

  task automatic test_random();
    logic [5:0] traj[$];
    int steps, exp_steps, kind, r, last_idx;
    bit to;
    do_reset();
    bus.run = 1'b1;
    for (int ep = 1; ep <= 24; ep++) begin
      traj = {};
      for (int i = 0; i < 16; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 7)       traj.push_back(6'(safe_cells[$urandom_range(0, safe_cells.size() - 1)]));
        else if (r == 7) traj.push_back(6'(hole_cells[$urandom_range(0, hole_cells.size() - 1)]));
        else if (r == 8) traj.push_back(6'($urandom_range(26, 63)));
        else             traj.push_back(6'd25);
      end
      if (m_consec == 7)
        foreach (traj[i]) if (traj[i] == 6'd25) traj[i] = 6'd1;
      ref_episode(traj, exp_steps, kind);
      ref_account(kind);
      last_idx = (exp_steps - 1 < traj.size()) ? exp_steps - 1 : traj.size() - 1;
      play_episode(traj, steps, to);
      total++;
      if (to) begin bad++; $display("FAIL rand_stall: ep %0d got stalled required ENDEP", ep); end
      total++;
      if (steps != exp_steps || bus.step_cnt !== 5'(exp_steps)) begin
        bad++; $display("FAIL rand_steps: ep %0d got %0d/%0d required %0d", ep, steps, bus.step_cnt, exp_steps);
      end
      total++;
      if ({bus.current_st, bus.goal_cnt, bus.episode} !== {traj[last_idx], 10'(m_goals), 10'(ep)}) begin
        bad++; $display("FAIL rand_counts: ep %0d got st=%0d goals=%0d ep=%0d required %0d/%0d/%0d",
                        ep, bus.current_st, bus.goal_cnt, bus.episode, traj[last_idx], m_goals, ep);
      end
      @(negedge clk);
      total++;
      if ({bus.epsilon, bus.agent_start} !== {16'(m_eps), 1'b1}) begin
        bad++; $display("FAIL rand_eps: ep %0d got eps=%h start=%b required %h/1",
                        ep, bus.epsilon, bus.agent_start, m_eps);
      end
      $display("rand ep %0d: kind=%0d steps=%0d goals=%0d eps=%h", ep, kind, steps, bus.goal_cnt, bus.epsilon);
    end
  endtask

  task automatic test_convergence();
    logic [5:0] traj[$];
    int steps, len;
    bit to;
    do_reset();
    bus.run = 1'b1;
    for (int ep = 1; ep <= 8; ep++) begin
      traj = {};
      len = int'($urandom_range(0, 13));
      for (int i = 0; i < len; i++)
        traj.push_back(6'(safe_cells[$urandom_range(0, safe_cells.size() - 1)]));
      traj.push_back(6'd25);
      ref_account(0);
      play_episode(traj, steps, to);
      total++;
      if (to || steps != len + 1) begin
        bad++; $display("FAIL conv_steps: ep %0d got %0d (stall=%b) required %0d", ep, steps, to, len + 1);
      end
      @(negedge clk);
      total++;
      if ({bus.goal_cnt, bus.epsilon} !== {10'(ep), 16'(m_eps)}) begin
        bad++; $display("FAIL conv_counts: ep %0d got goals=%0d eps=%h required %0d/%h",
                        ep, bus.goal_cnt, bus.epsilon, ep, m_eps);
      end
      total++;
      if (ep < 8 && bus.agent_start !== 1'b1) begin
        bad++; $display("FAIL conv_restart: ep %0d got start=%b required 1", ep, bus.agent_start);
      end else if (ep == 8 && {bus.finish, bus.fail, bus.busy, bus.agent_start, bus.episode} !== {4'b1000, 10'd8}) begin
        bad++; $display("FAIL conv_finish: got fin=%b fail=%b busy=%b start=%b ep=%0d required 1/0/0/0/8",
                        bus.finish, bus.fail, bus.busy, bus.agent_start, bus.episode);
      end
      $display("conv ep %0d: steps=%0d goals=%0d finish=%b", ep, steps, bus.goal_cnt, bus.finish);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({bus.finish, bus.busy, bus.agent_start, bus.episode, bus.goal_cnt} !== {3'b100, 10'd8, 10'd8}) begin
        bad++; $display("FAIL conv_hold: got fin=%b busy=%b start=%b ep=%0d goals=%0d required 1/0/0/8/8",
                        bus.finish, bus.busy, bus.agent_start, bus.episode, bus.goal_cnt);
      end
    end
    bus.run = 1'b0;
    @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.agent_start, bus.finish, bus.episode, bus.goal_cnt, bus.epsilon} !== {2'b10, 10'd0, 10'd0, 16'hF000}) begin
      bad++; $display("FAIL conv_relaunch: got start=%b fin=%b ep=%0d goals=%0d eps=%h required 1/0/0/0/F000",
                      bus.agent_start, bus.finish, bus.episode, bus.goal_cnt, bus.epsilon);
    end
    $display("relaunch after convergence: start=%b eps=%h", bus.agent_start, bus.epsilon);
  endtask

  task automatic test_budget();
    logic [5:0] traj[$];
    int steps, kind;
    bit to;
    do_reset();
    bus.run = 1'b1;
    for (int ep = 1; ep <= 256; ep++) begin
      if ($urandom_range(0, 3) == 0 && m_consec < 7) begin
        traj = {6'd25};
        kind = 0;
      end else begin
        if ($urandom_range(0, 1) == 0) traj = {6'(hole_cells[$urandom_range(0, hole_cells.size() - 1)])};
        else                           traj = {6'($urandom_range(26, 63))};
        kind = 1;
      end
      ref_account(kind);
      play_episode(traj, steps, to);
      total++;
      if (to || steps != 1 || {bus.episode, bus.goal_cnt} !== {10'(ep), 10'(m_goals)}) begin
        bad++; $display("FAIL budget_ep: ep %0d got steps=%0d stall=%b ep=%0d goals=%0d required 1/0/%0d/%0d",
                        ep, steps, to, bus.episode, bus.goal_cnt, ep, m_goals);
      end
      @(negedge clk);
      total++;
      if (bus.epsilon !== 16'(m_eps) || bus.epsilon < 16'h0100) begin
        bad++; $display("FAIL budget_eps: ep %0d got %h required %h", ep, bus.epsilon, m_eps);
      end
      $display("budget ep %0d: kind=%0d goals=%0d eps=%h", ep, kind, bus.goal_cnt, bus.epsilon);
    end
    total++;
    if ({bus.fail, bus.finish, bus.busy, bus.agent_start, bus.episode, bus.epsilon, bus.goal_cnt}
        !== {4'b1000, 10'd256, 16'h0100, 10'(m_goals)}) begin
      bad++; $display("FAIL budget_end: got fail=%b fin=%b busy=%b ep=%0d eps=%h goals=%0d required 1/0/0/256/0100/%0d",
                      bus.fail, bus.finish, bus.busy, bus.episode, bus.epsilon, bus.goal_cnt, m_goals);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({bus.fail, bus.agent_start, bus.busy} !== 3'b100) begin
      bad++; $display("FAIL budget_hold: got fail=%b start=%b busy=%b required 1/0/0",
                      bus.fail, bus.agent_start, bus.busy);
    end
  endtask

  task automatic test_reset_mid_step();
    int guard;
    do_reset();
    bus.run = 1'b1;
    guard = 0;
    while (bus.agent_en !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (bus.agent_en !== 1'b1) begin bad++; $display("FAIL midstep_reach: got en=0 required 1"); end
    bus.step_done = 1'b1;
    bus.next_state = 6'd25;
    enb = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.agent_en, bus.busy, bus.print, bus.agent_start, bus.current_st, bus.step_cnt,
         bus.episode, bus.goal_cnt, bus.epsilon} !== {4'b0000, 6'd1, 5'd0, 10'd0, 10'd0, 16'hF000}) begin
      bad++; $display("FAIL midstep_reset: got en=%b busy=%b st=%0d steps=%0d ep=%0d goals=%0d eps=%h required 0/0/1/0/0/0/F000",
                      bus.agent_en, bus.busy, bus.current_st, bus.step_cnt, bus.episode, bus.goal_cnt, bus.epsilon);
    end
    enb = 1'b0;
    bus.step_done = 1'b0;
    bus.run = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.busy, bus.agent_start} !== 2'b00) begin
      bad++; $display("FAIL midstep_idle: got busy=%b start=%b required 0/0", bus.busy, bus.agent_start);
    end
    $display("reset mid-step: st=%0d busy=%b", bus.current_st, bus.busy);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion required summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    enb = 1'b1;
    bus.run = 1'b0;
    bus.step_done = 1'b0;
    bus.next_state = '0;
    test_reset();
    test_hole();
    test_goal();
    test_timeout();
    test_random();
    test_convergence();
    test_budget();
    test_reset_mid_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/episode_scheduler.md
Name: episode_scheduler

Overview:
- Episode-level sequencer for the Q-learning gridworld agent on the 5x5 grid (states 1..25).
- Starts each episode at the start cell and steps the agent through a step/done handshake.
- Ends the episode on goal, hole or step limit, and decays epsilon once per episode.
- Stops the run on convergence (finish) or when the episode budget is exhausted (fail).
- Sits between the top-level run control and the QLearningAgent/StateSelector/RewardGenerator datapath.

Parameters:
- START_STATE, 6'd1, cell loaded at the start of every episode.
- GOAL_STATE, 6'd25, terminal success cell.
- HOLE_MASK, 26'h05A_41A0, bit n set means cell n is a hole (cells 5,7,8,14,17,19,20,22).
- MAX_STEPS, 15, steps allowed per episode before forced end.
- MAX_EPISODES, 256, episode budget per run.
- CONV_GOALS, 8, consecutive goal episodes that declare convergence.
- EPS_INIT, 16'hF000, epsilon at run start.
- EPS_MIN, 16'h0100, epsilon floor.
- EPS_SHIFT, 4, decay amount per episode is eps>>EPS_SHIFT.

Ports:
- clk, in, 1, system clock.
- enb, in, 1, synchronous active-high reset.
- run, in, 1, level; sampled in IDLE to launch a run.
- step_done, in, 1, agent has produced next_state for the current step; honoured only in STEP.
- next_state, in, 6, agent/StateSelector next cell; valid when step_done=1.
- agent_start, out, 1, one-cycle pulse telling the agent a new episode begins.
- agent_en, out, 1, agent step enable.
- current_st, out, 6, current grid cell.
- epsilon, out, 16, exploration threshold driven to the agent.
- episode, out, 10, episodes started in this run.
- step_cnt, out, 5, steps taken in the current episode.
- goal_cnt, out, 10, total goal episodes in this run.
- print, out, 1, trace-valid strobe.
- busy, out, 1, high in every state except IDLE, DONE and FAIL.
- finish, out, 1, sticky: converged.
- fail, out, 1, sticky: budget exhausted without convergence.

Behaviour:
- Reset: enb=1 at any clock edge, in any state, forces IDLE on that edge and sets all outputs to 0, except current_st=START_STATE and epsilon=EPS_INIT. It also clears consec (consecutive-goal counter, internal).
- FSM states: IDLE, INIT, STEP, EVAL, ENDEP, DONE, FAIL.
- IDLE:
  - run=1 moves to INIT on the next edge.
  - On that transition: episode, goal_cnt and consec reset to 0, epsilon reloads EPS_INIT, finish and fail clear.
- INIT (1 cycle):
  - agent_start=1, agent_en=0.
  - On exit: current_st<=START_STATE, step_cnt<=0, episode<=episode+1.
  - Next state: STEP.
- STEP:
  - agent_en=1, print=1.
  - Waits any number of cycles for step_done.
  - When step_done=1: current_st<=next_state, step_cnt<=step_cnt+1, next state EVAL.
- EVAL (1 cycle):
  - print=1, agent_en=0.
  - End-of-episode checks, in priority order, use the updated current_st and step_cnt:
    - current_st==GOAL_STATE: goal. goal_cnt+1, consec+1, go to ENDEP.
    - HOLE_MASK[current_st]=1: hole. consec<=0, go to ENDEP.
    - step_cnt==MAX_STEPS: timeout. consec<=0, go to ENDEP.
    - Otherwise return to STEP.
  - A next_state value above 25 is treated as a hole.
- ENDEP (1 cycle):
  - epsilon<=max(epsilon-(epsilon>>EPS_SHIFT), EPS_MIN); the subtraction is unsigned 16-bit.
  - If consec==CONV_GOALS: go to DONE, finish<=1.
  - Else if episode==MAX_EPISODES: go to FAIL, fail<=1.
  - Else go to INIT.
  - Convergence wins if both hold in the same cycle.
- DONE and FAIL:
  - Hold all counters and outputs.
  - Return to IDLE only when run=0, so a held run does not relaunch.
- Latency per step: 2 cycles minimum (STEP with immediate step_done, then EVAL).
- Fixed overhead per episode: INIT and ENDEP, one cycle each.
- Counter ranges: episode never exceeds MAX_EPISODES; step_cnt never exceeds MAX_STEPS; goal_cnt saturates at 1023.
- step_done outside STEP is ignored.
- run is ignored outside IDLE, DONE and FAIL.

Decomposition:
- Shared package gridworld_pkg holds:
  - the state enum;
  - the START/GOAL/HOLE_MASK constants, which are also used by RewardGenerator;
  - the 6-bit cell typedef and the 16-bit epsilon typedef.
- One sub-module, eps_decay: combinational shift-subtract-clamp. Inputs eps_in, min; output eps_out.

Test Plan:
- Agent model returns 2,3,4,9,10,15,20 -> episode ends at step 7 on hole 20 and consec stays 0. epsilon goes F000 -> E100 (F000-0F00).
- Agent model returns 2,3,4,9,10,15,16,21,... to 25 within 15 steps -> goal_cnt=1 and a new agent_start pulse 1 cycle after ENDEP.
- Agent model stays on non-terminal cell 1 -> step_cnt reaches 15, then INIT. episode increments to 2.
- Eight consecutive goal episodes from run=1 -> finish=1 after episode 8; busy=0; state held with run=1; IDLE after run=0.
- Agent model never reaches goal -> fail=1 with episode=256. epsilon clamps at 0100, never below.
- Assert enb mid-STEP with step_done=1 in the same cycle -> next cycle IDLE, agent_en=0, current_st=1, counters 0.
